// File: rtl/led_status_pkg.sv
// Shared types and helpers for the board status indicator.
package led_status_pkg;

  // Running-light pattern selection, encoded as seen on the mode pins.
  typedef enum logic [1:0] {
    JOHNSON = 2'd0,
    RING    = 2'd1,
    BOUNCE  = 2'd2,
    BLINK   = 2'd3
  } led_mode_e;

  // Travel direction of the BOUNCE one-hot pattern.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } flow_dir_e;

  // Widest running light the initial-pattern helper can describe.
  localparam int FLOW_MAX_W = 64;

  // Pattern loaded into the running light when a mode is entered.
  // One-hot modes start with LED 0 lit; the others start dark.
  function automatic logic [FLOW_MAX_W-1:0] flow_init(input led_mode_e mode, input int n);
    logic [FLOW_MAX_W-1:0] pat;
    pat = '0;
    if ((mode == RING || mode == BOUNCE) && n > 0) begin
      pat[0] = 1'b1;
    end
    return pat;
  endfunction

endpackage

// File: rtl/act_stretch.sv
// One activity channel: synchronises a raw line, detects either edge and
// stretches it into a pulse of 2^STRETCH_W-1 clocks.
module act_stretch #(
  parameter int   STRETCH_W = 20,
  parameter logic ACT_IDLE  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic act_in,
  output logic led
);

  localparam logic [STRETCH_W-1:0] HOLD    = '1;
  localparam logic [STRETCH_W-1:0] CNT_ONE = {{(STRETCH_W-1){1'b0}}, 1'b1};

  logic                 meta;
  logic                 sync;
  logic                 prev;
  logic                 edge_det;
  logic [STRETCH_W-1:0] cnt;
  logic [STRETCH_W-1:0] cnt_next;

  // Two-FF synchroniser plus one delayed copy for edge detection; all reset
  // to the idle level so a quiet line never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= ACT_IDLE;
      sync <= ACT_IDLE;
      prev <= ACT_IDLE;
    end else begin
      meta <= act_in;
      sync <= meta;
      prev <= sync;
    end
  end

  // Reload on any edge (wins over the decrement), otherwise count down to 0.
  always_comb begin
    edge_det = sync ^ prev;
    cnt_next = cnt;
    if (edge_det) begin
      cnt_next = HOLD;
    end else if (cnt != '0) begin
      cnt_next = cnt - CNT_ONE;
    end
  end

  // Counter and registered LED; the LED follows the counter's next value so
  // it rises on the same edge as the reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      led <= 1'b0;
    end else begin
      cnt <= cnt_next;
      led <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/led_status_ctrl.sv
// Board status indicator: a mode-selectable running light driven from a
// prescaled tick, plus N_ACT stretched activity LEDs.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int   N_FLOW    = 4,
  parameter int   N_ACT     = 4,
  parameter int   DIV_W     = 22,
  parameter int   STRETCH_W = 20,
  parameter logic ACT_IDLE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [N_ACT-1:0]  act_in,
  output logic [N_FLOW-1:0] led_flow,
  output logic [N_ACT-1:0]  led_act
);

  localparam logic [DIV_W-1:0] PRESC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [1:0]        mode_meta;
  logic [1:0]        mode_sync;
  led_mode_e         mode_new;
  led_mode_e         mode_q;
  led_mode_e         mode_q_next;
  logic [DIV_W-1:0]  presc;
  logic [DIV_W-1:0]  presc_next;
  logic              tick;
  logic [N_FLOW-1:0] flow;
  logic [N_FLOW-1:0] flow_next;
  flow_dir_e         dir;
  flow_dir_e         dir_next;

  // Two-FF synchroniser for the (switch-driven) mode pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta <= '0;
      mode_sync <= '0;
    end else begin
      mode_meta <= mode;
      mode_sync <= mode_meta;
    end
  end

  // Next-state logic: a mode change restarts the pattern and prescaler and
  // overrides a coincident tick; otherwise the pattern advances on tick.
  always_comb begin
    mode_new    = led_mode_e'(mode_sync);
    tick        = &presc;
    mode_q_next = mode_q;
    flow_next   = flow;
    dir_next    = dir;
    presc_next  = presc + PRESC_ONE;
    if (mode_new != mode_q) begin
      mode_q_next = mode_new;
      flow_next   = N_FLOW'(flow_init(mode_new, N_FLOW));
      dir_next    = DIR_UP;
      presc_next  = '0;
    end else if (tick) begin
      case (mode_q)
        JOHNSON: flow_next = {flow[N_FLOW-2:0], ~flow[N_FLOW-1]};
        RING:    flow_next = {flow[N_FLOW-2:0], flow[N_FLOW-1]};
        BOUNCE: begin
          if (dir == DIR_UP) begin
            flow_next = flow << 1;
            if (flow[N_FLOW-2]) dir_next = DIR_DOWN;
          end else begin
            flow_next = flow >> 1;
            if (flow[1]) dir_next = DIR_UP;
          end
        end
        BLINK:   flow_next = ~flow;
        default: flow_next = flow;
      endcase
    end
  end

  // Pattern state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= JOHNSON;
      flow   <= '0;
      dir    <= DIR_UP;
      presc  <= '0;
    end else begin
      mode_q <= mode_q_next;
      flow   <= flow_next;
      dir    <= dir_next;
      presc  <= presc_next;
    end
  end

  assign led_flow = flow;

  for (genvar gi = 0; gi < N_ACT; gi++) begin : g_act
    act_stretch #(
      .STRETCH_W (STRETCH_W),
      .ACT_IDLE  (ACT_IDLE)
    ) u_act (
      .clk    (clk),
      .rst_n  (rst_n),
      .act_in (act_in[gi]),
      .led    (led_act[gi])
    );
  end

endmodule
